arbitrated_memory: RTL
======================

# arbitrated_memory

Parametrised, multi-channel, byte-lane-writable synchronous word memory with a built-in bus arbiter. It is the next generation of the single-port simulation memory. It replaces the ad-hoc CPU/IOP ownership flag with a request/acknowledge handshake per channel, selectable round-robin or fixed-priority arbitration, and configurable wait states. It sits between the CPU, IOP and any future bus masters and the backing store, and it serves both simulation and synthesis.

## Interface
Parameters:
- CHANNELS, 2, number of requesting masters (1..8)
- DEPTH_LOG2, 10, log2 of words stored
- WAIT_STATES, 0, extra access cycles inserted before each access (0..15)
- ROUND_ROBIN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  CHANNELS  per-channel request level
- addr  in  17*CHANNELS  word address per channel; channel k occupies bits [17k+16:17k]
- wdata  in  32*CHANNELS  write data per channel; byte lane 0 is the most significant byte
- be  in  4*CHANNELS  byte-lane write enables per channel; 0000 means read
- grant  out  CHANNELS  one-hot; shows the channel currently owning the memory
- ack  out  CHANNELS  one-cycle completion pulse to the served channel
- rdata  out  32  read data, valid while any ack bit is high

## Operation
- Storage is four byte-lane arrays, each 2^DEPTH_LOG2 entries deep. Benches preload them hierarchically. All entries are zero at time 0. Reset does not clear storage.
- Addresses alias: index = addr & (2^DEPTH_LOG2-1). Bits above DEPTH_LOG2 are ignored and are not an error.
- Handshake:
  - A master raises req and holds addr/wdata/be stable until it samples ack high.
  - The master must drop req on the edge where it samples ack. If req is still high in IDLE afterwards, it is treated as a new request.
- State machine: IDLE, BUSY, DONE.
  - IDLE: if any req is high, pick the winner. Latch its addr, be and wdata. Set grant to the winner's one-hot. Load the wait counter with WAIT_STATES. Go to BUSY. With no request, stay in IDLE with grant=0.
  - BUSY: if the counter is nonzero, decrement it. If it is zero, perform the access:
    - Write every lane whose latched be bit is set.
    - Load rdata with the stored word as it was before the write (read-before-write).
    - Set ack[winner]=1 and go to DONE.
  - DONE: clear ack and grant, ignore all req, go to IDLE.
- Arbitration:
  - Round-robin: search from last_granted+1 upward with wrap-around. last_granted updates on every grant.
  - Fixed priority: the lowest asserted index wins and last_granted is unused.
  - CHANNELS=1 degenerates to a single port in both modes.
- rdata holds its value after DONE until the next access completes. Writes also update rdata, with the pre-write word.
- Requests arriving during BUSY/DONE wait. They are never dropped while req stays high.

## Timing
- Reset values while reset is low:
  - state=IDLE; grant=0, ack=0, rdata=0.
  - last_granted=CHANNELS-1, so channel 0 wins the first round-robin arbitration.
  - The wait counter is cleared.
- Reset mid-access abandons the access. No lane write occurs unless the access edge had already passed.
- Latency, with req high before edge E0:
  - grant is high after E0.
  - The access happens at edge E0+1+WAIT_STATES.
  - ack and rdata are valid during the cycle after that edge.
  - Request to ack is therefore 2+WAIT_STATES cycles.
- Throughput: one access per 3+WAIT_STATES cycles. This holds back-to-back across channels and for a single channel that re-requests immediately.
- Simultaneous requests are resolved only in IDLE. Changes to req/addr while BUSY have no effect on the current access.
- The counter is 4 bits. WAIT_STATES values above 15 are not allowed.

## Test plan
- Preload word 0x005=0x12345678, WAIT_STATES=0, then ch0 reads 0x005. Required: grant=01 after the first edge, ack[0] in cycle 2, rdata=0x12345678.
- Preload 0x12345678, then ch1 writes 0x005 with be=0101, wdata=0xAABBCCDD, then reads 0x005. Required: rdata on the write ack is 0x12345678 and the following read returns 0x12BB56DD.
- ROUND_ROBIN=1, ch0 and ch1 re-request continuously after reset. Required: grants alternate 0,1,0,1, with acks every 3 cycles.
- ROUND_ROBIN=0, both channels continuously requesting. Required: ch0 is served every 3 cycles and ch1 never. Once ch0 drops req, ch1 is acked within 3 cycles.
- WAIT_STATES=3, DEPTH_LOG2=10, ch0 reads 0x405 after preloading 0x005=0xCAFEF00D. Required: ack 5 cycles after req, rdata=0xCAFEF00D (aliasing).
- WAIT_STATES=3, ch0 writes be=1111 0xFFFFFFFF to 0x010, and reset is pulsed low one cycle after grant. Required: grant/ack/rdata=0, no ack pulse, and a later read of 0x010 returns the original value.

Source files
------------

// File: rtl/arbitrated_memory.sv
// arbitrated_memory: multi-channel byte-lane word memory with a request/ack arbiter
module arbitrated_memory #(
  parameter int CHANNELS    = 2,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 0,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [CHANNELS-1:0]    req_i,
  input  logic [17*CHANNELS-1:0] addr_i,
  input  logic [32*CHANNELS-1:0] wdata_i,
  input  logic [4*CHANNELS-1:0]  be_i,
  output logic [CHANNELS-1:0]    grant_o,
  output logic [CHANNELS-1:0]    ack_o,
  output logic [31:0]            rdata_o
);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IW-1:0]         last_q, last_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [CHANNELS-1:0]   grant_q, grant_d;
  logic [CHANNELS-1:0]   ack_q, ack_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [IW-1:0]         pick;
  logic                  found;
  int                    k;
  logic                  access;
  logic [7:0]            rd_lane [4];
  logic [31:0]           word;
  assign access  = (state_q == BUSY) && (cnt_q == 4'd0);
  assign word    = {rd_lane[0], rd_lane[1], rd_lane[2], rd_lane[3]};
  assign grant_o = grant_q;
  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
  // winner search: round-robin starts just after the last grant, fixed priority starts at 0
  always_comb begin
    found = 1'b0;
    pick  = '0;
    k     = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      k = (ROUND_ROBIN != 0) ? (int'(last_q) + 1 + i) % CHANNELS : i;
      if (!found && req_i[IW'(k)]) begin
        found = 1'b1;
        pick  = IW'(k);
      end
    end
  end
  // IDLE latches the winner's request, BUSY counts wait states then accesses, DONE retires
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (|req_i) begin
        state_d = BUSY;
        last_d  = pick;
        grant_d = CHANNELS'(1) << pick;
        idx_d   = addr_i[17*pick +: DEPTH_LOG2];
        be_d    = be_i[4*pick +: 4];
        wdata_d = wdata_i[32*pick +: 32];
        cnt_d   = 4'(WAIT_STATES);
      end
      BUSY: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        state_d = DONE;
        ack_d   = grant_q;
        rdata_d = word;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        ack_d   = '0;
      end
    endcase
  end
  // control registers; reset abandons any access in flight
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(CHANNELS - 1);
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  // one storage array per byte lane; lane 0 is the most significant byte, enabled by be[3]
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem_q [2**DEPTH_LOG2];
    assign rd_lane[l] = mem_q[idx_q];
    // lane write on the access edge; storage is never reset
    always_ff @(posedge clk_i)
      if (access && be_q[3-l]) mem_q[idx_q] <= wdata_q[31-8*l -: 8];
  end
endmodule
